// File: rtl/lsu.sv
// lsu: load/store unit for the RAMP RV32 core.
// Runs one data-bus transaction at a time over a req/gnt/rvalid handshake
// and returns an aligned, sign- or zero-extended load result tagged with rd.
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses complete as error responses
//   undefined -> misaligned accesses are performed at natural alignment
module lsu (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        mem_sign_i,
    input  logic [1:0]  mem_width_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_addr_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic [4:0]  resp_rd_o,
    output logic        resp_err_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  width_q, width_d;
    logic        sign_q, sign_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        err_q, err_d;

    logic        accept_s;
    logic        err_s;
    logic [1:0]  off_s;

    // Byte enables for a given width and (already aligned) byte offset.
    function automatic logic [3:0] byte_en(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = 4'b0011 << {off[1], 1'b0};
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    // Replicate store data across all lanes so the byte enables pick the right one.
    function automatic logic [31:0] store_lanes(input logic [1:0] width, input logic [31:0] data);
        case (width)
            2'b00:   store_lanes = {4{data[7:0]}};
            2'b01:   store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

    // Pull the addressed byte/half out of the bus word and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] data, input logic [1:0] width,
                                                input logic zext, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = data[7:0];
            2'b01:   b = data[15:8];
            2'b10:   b = data[23:16];
            default: b = data[31:24];
        endcase
        h = off[1] ? data[31:16] : data[15:0];
        case (width)
            2'b00:   load_extend = zext ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   load_extend = zext ? {16'h0000, h} : {{16{h[15]}}, h};
            default: load_extend = data;
        endcase
    endfunction

    // Classify the incoming request: error condition and effective byte offset.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        err_s = (mem_width_i == 2'b11)
              | ((mem_width_i == 2'b01) & addr_i[0])
              | ((mem_width_i == 2'b10) & (addr_i[1:0] != 2'b00));
        off_s = addr_i[1:0];
`else
        err_s = (mem_width_i == 2'b11);
        case (mem_width_i)
            2'b01:   off_s = {addr_i[1], 1'b0};
            2'b10:   off_s = 2'b00;
            default: off_s = addr_i[1:0];
        endcase
`endif
    end

    assign accept_s = req_valid_i & (state_q == ST_IDLE) & (mem_read_i | mem_write_i);

    // Next-state and latched-field logic for the transaction FSM.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        width_d = width_q;
        sign_d  = sign_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    // Both read and write set is treated as a store.
                    we_d    = mem_write_i & ~err_s;
                    addr_d  = {addr_i[31:2], 2'b00};
                    be_d    = err_s ? 4'b0000 : byte_en(mem_width_i, off_s);
                    wdata_d = store_lanes(mem_width_i, wdata_i);
                    width_d = mem_width_i;
                    sign_d  = mem_sign_i;
                    off_d   = off_s;
                    rdata_d = 32'h0000_0000;
                    rd_d    = rd_addr_i;
                    err_d   = err_s;
                    state_d = err_s ? ST_RESP : ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dbus_gnt_i) begin
                    state_d = we_q ? ST_RESP : ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dbus_rvalid_i) begin
                    rdata_d = load_extend(dbus_rdata_i, width_q, sign_q, off_q);
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transaction-field registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0000_0000;
            width_q <= 2'b00;
            sign_q  <= 1'b0;
            off_q   <= 2'b00;
            rdata_q <= 32'h0000_0000;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            width_q <= width_d;
            sign_q  <= sign_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode the state register only; the rest are registers.
    assign req_ready_o  = (state_q == ST_IDLE);
    assign dbus_req_o   = (state_q == ST_REQ);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_rd_o    = rd_q;
    assign resp_err_o   = err_q;
    assign dbus_we_o    = we_q;
    assign dbus_addr_o  = addr_q;
    assign dbus_be_o    = be_q;
    assign dbus_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed scoreboard bench for lsu. Stimulus tasks push the expected
// response; an independent monitor pops and compares on every resp_valid_o.
module tb_lsu;

    logic        clk;
    logic        rst_ni;
    logic        req_valid;
    logic        req_ready_o;
    logic        mem_read, mem_write, mem_sign;
    logic [1:0]  mem_width;
    logic [31:0] addr, wdata;
    logic [4:0]  rd_addr;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic [4:0]  resp_rd_o;
    logic        resp_err_o;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        gnt, rvalid;
    logic [31:0] bus_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    lsu dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .mem_read_i    (mem_read),
        .mem_write_i   (mem_write),
        .mem_sign_i    (mem_sign),
        .mem_width_i   (mem_width),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .rd_addr_i     (rd_addr),
        .resp_valid_o  (resp_valid_o),
        .resp_rdata_o  (resp_rdata_o),
        .resp_rd_o     (resp_rd_o),
        .resp_err_o    (resp_err_o),
        .dbus_req_o    (dbus_req_o),
        .dbus_we_o     (dbus_we_o),
        .dbus_addr_o   (dbus_addr_o),
        .dbus_be_o     (dbus_be_o),
        .dbus_wdata_o  (dbus_wdata_o),
        .dbus_gnt_i    (gnt),
        .dbus_rvalid_i (rvalid),
        .dbus_rdata_i  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic [4:0] rd, input logic err);
        resp_t r;
        r.rdata = rdata;
        r.rd    = rd;
        r.err   = err;
        exp_q.push_back(r);
    endtask

    // Monitor: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin : monitor
        resp_t e;
        if (rst_ni && resp_valid_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: got rd=%0d rdata=%h err=%b, expected none",
                         resp_rd_o, resp_rdata_o, resp_err_o);
            end else begin
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata_o, e.rdata);
                chk("resp_rd",    32'(resp_rd_o), 32'(e.rd));
                chk("resp_err",   32'(resp_err_o), 32'(e.err));
            end
        end
    end

    // One complete operation with a cooperative bus model and hand-computed expectations.
    task automatic op(input logic rd_en, input logic wr_en, input logic sgn, input logic [1:0] wid,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                      input int gdly, input int rvdly, input logic [31:0] brdata,
                      input logic exp_bus, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                      input logic [31:0] exp_wdata, input logic [31:0] exp_rdata, input logic exp_err);
        push_exp(exp_rdata, rd, exp_err);
        mem_read  = rd_en;
        mem_write = wr_en;
        mem_sign  = sgn;
        mem_width = wid;
        addr      = a;
        wdata     = wd;
        rd_addr   = rd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (exp_bus) begin
            chk("dbus_req",  32'(dbus_req_o), 32'd1);
            chk("dbus_addr", dbus_addr_o, exp_addr);
            chk("dbus_be",   32'(dbus_be_o), 32'(exp_be));
            chk("dbus_we",   32'(dbus_we_o), 32'(wr_en));
            if (wr_en) chk("dbus_wdata", dbus_wdata_o, exp_wdata);
            for (int i = 0; i < gdly; i++) begin
                @(posedge clk); #1;
                chk("req_hold", 32'(dbus_req_o), 32'd1);
            end
            gnt = 1'b1;
            @(posedge clk); #1;
            gnt = 1'b0;
            if (!wr_en) begin
                for (int i = 0; i < rvdly; i++) begin
                    @(posedge clk); #1;
                    chk("wait_noresp", 32'(resp_valid_o), 32'd0);
                end
                bus_rdata = brdata;
                rvalid    = 1'b1;
                @(posedge clk); #1;
                rvalid    = 1'b0;
                bus_rdata = 32'h0;
            end
        end else begin
            chk("no_dbus_req", 32'(dbus_req_o), 32'd0);
        end
        chk("resp_valid", 32'(resp_valid_o), 32'd1);
        @(posedge clk); #1;
        chk("ready_after", 32'(req_ready_o), 32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_ni = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_sign = 1'b0;
        mem_width = 2'b00; addr = 32'h0; wdata = 32'h0; rd_addr = 5'd0;
        gnt = 1'b0; rvalid = 1'b0; bus_rdata = 32'h0;
        #12;
        chk("rst_ready",      32'(req_ready_o), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_resp_rdata", resp_rdata_o, 32'h0);
        chk("rst_resp_rd",    32'(resp_rd_o), 32'd0);
        chk("rst_resp_err",   32'(resp_err_o), 32'd0);
        chk("rst_dbus_req",   32'(dbus_req_o), 32'd0);
        chk("rst_dbus_we",    32'(dbus_we_o), 32'd0);
        chk("rst_dbus_addr",  dbus_addr_o, 32'h0);
        chk("rst_dbus_be",    32'(dbus_be_o), 32'd0);
        chk("rst_dbus_wdata", dbus_wdata_o, 32'h0);
        #10 rst_ni = 1'b1;
        @(posedge clk); #1;

        //  rd    wr    sgn   wid    addr          wdata         rd     g  rv brdata        bus   exp_addr      be       exp_wdata     exp_rdata     err
        op(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'h0,        5'd5,  0, 0, 32'hDEADBEEF, 1'b1, 32'h0000_1000, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0);
        op(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_1003, 32'h0,        5'd6,  0, 0, 32'h80123456, 1'b1, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0);
        op(1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_1003, 32'h0,        5'd7,  0, 1, 32'h80123456, 1'b1, 32'h0000_1000, 4'b1000, 32'h0,        32'h00000080, 1'b0);
        op(1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_2002, 32'h1234ABCD, 5'd8,  3, 0, 32'h0,        1'b1, 32'h0000_2000, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0);
        op(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_2002, 32'h0,        5'd9,  1, 2, 32'h80017FFF, 1'b1, 32'h0000_2000, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0);
        op(1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_2000, 32'h0,        5'd10, 0, 0, 32'h80017FFF, 1'b1, 32'h0000_2000, 4'b0011, 32'h0,        32'h00007FFF, 1'b0);
        op(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_3001, 32'h000000A5, 5'd11, 0, 0, 32'h0,        1'b1, 32'h0000_3000, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0);
        op(1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_3004, 32'hCAFEF00D, 5'd12, 1, 0, 32'h0,        1'b1, 32'h0000_3004, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0);
        op(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_1001, 32'h0,        5'd13, 0, 0, 32'h11228344, 1'b1, 32'h0000_1000, 4'b0010, 32'h0,        32'hFFFFFF83, 1'b0);
        op(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_1000, 32'h0,        5'd14, 0, 0, 32'h0,        1'b0, 32'h0,         4'b0000, 32'h0,        32'h0,        1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
        op(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_1001, 32'h0,        5'd15, 0, 0, 32'h0,        1'b0, 32'h0,         4'b0000, 32'h0,        32'h0,        1'b1);
        op(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_1003, 32'h0,        5'd16, 0, 0, 32'h0,        1'b0, 32'h0,         4'b0000, 32'h0,        32'h0,        1'b1);
`else
        op(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_1001, 32'h0,        5'd15, 0, 0, 32'h01020304, 1'b1, 32'h0000_1000, 4'b1111, 32'h0,        32'h01020304, 1'b0);
        op(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_1003, 32'h0,        5'd16, 0, 0, 32'h80017FFF, 1'b1, 32'h0000_1000, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0);
`endif

        // Valid with neither read nor write is ignored.
        mem_read = 1'b0; mem_write = 1'b0; mem_width = 2'b10; req_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("ignore_ready", 32'(req_ready_o), 32'd1);
            chk("ignore_req",   32'(dbus_req_o), 32'd0);
        end
        req_valid = 1'b0;

        // req_valid held high across a busy load: second request accepted once.
        push_exp(32'h0BADF00D, 5'd17, 1'b0);
        push_exp(32'h0, 5'd18, 1'b1);
        mem_read = 1'b1; mem_write = 1'b0; mem_sign = 1'b0; mem_width = 2'b10;
        addr = 32'h0000_4000; rd_addr = 5'd17; req_valid = 1'b1;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b1; mem_width = 2'b11; addr = 32'h0000_5000; rd_addr = 5'd18;
        chk("b2b_ready_t1", 32'(req_ready_o), 32'd0);
        chk("b2b_req_t1",   32'(dbus_req_o), 32'd1);
        gnt = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b0;
        chk("b2b_ready_t2", 32'(req_ready_o), 32'd0);
        bus_rdata = 32'h0BADF00D; rvalid = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b0; bus_rdata = 32'h0;
        chk("b2b_ready_t3", 32'(req_ready_o), 32'd0);
        chk("b2b_resp_t3",  32'(resp_valid_o), 32'd1);
        @(posedge clk); #1;
        chk("b2b_ready_t4", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_resp_t5", 32'(resp_valid_o), 32'd1);
        chk("b2b_err_t5",  32'(resp_err_o), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("b2b_once", 32'(resp_valid_o), 32'd0);
        end

        // Asynchronous reset while in REQ.
        mem_read = 1'b1; mem_write = 1'b0; mem_width = 2'b10; addr = 32'h0000_1000;
        rd_addr = 5'd19; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rreq_req_before", 32'(dbus_req_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rreq_req_drop", 32'(dbus_req_o), 32'd0);
        chk("rreq_ready",    32'(req_ready_o), 32'd1);
        @(posedge clk); #3 rst_ni = 1'b1;
        @(posedge clk); #1;
        chk("rreq_idle_resp", 32'(resp_valid_o), 32'd0);

        // Asynchronous reset while in WAIT; late rvalid must be discarded.
        rd_addr = 5'd20; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; gnt = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b0;
        chk("rwait_ready_busy", 32'(req_ready_o), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        chk("rwait_req",   32'(dbus_req_o), 32'd0);
        chk("rwait_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk); #3 rst_ni = 1'b1;
        @(posedge clk); #1;
        bus_rdata = 32'h55AA55AA; rvalid = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (3) begin
            chk("rwait_no_resp", 32'(resp_valid_o), 32'd0);
            @(posedge clk); #1;
        end

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RAMP RV32 core. Consumes the memory control bundle produced by the instruction decoder (`mem_read`, `mem_write`, `mem_sign`, `mem_width`) together with the ALU-computed address and rs2 data. Runs one data-bus transaction at a time over a req/gnt/rvalid handshake and returns an aligned, sign- or zero-extended load result tagged with its destination register. Sits between the execute stage and the data memory / bus fabric.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clk_i` input 1: core clock.
- `rst_ni` input 1: asynchronous, active-low reset.
- `req_valid_i` input 1: execute stage presents a memory operation.
- `req_ready_o` output 1: LSU can accept; high only in IDLE.
- `mem_read_i` input 1: load operation.
- `mem_write_i` input 1: store operation.
- `mem_sign_i` input 1: func3[2]; 1 means zero-extend (LBU/LHU), 0 means sign-extend.
- `mem_width_i` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `addr_i` input 32: byte address.
- `wdata_i` input 32: store data (rs2).
- `rd_addr_i` input 5: load destination register.
- `resp_valid_o` output 1: one-cycle completion pulse; no backpressure.
- `resp_rdata_o` output 32: extended load data; 0 for stores and errors.
- `resp_rd_o` output 5: destination register of the completed operation.
- `resp_err_o` output 1: misaligned or illegal-width access; qualified by `resp_valid_o`.
- `dbus_req_o` output 1: bus request, held until granted.
- `dbus_we_o` output 1: 1 for store.
- `dbus_addr_o` output 32: word address, with `addr[1:0]` forced to 0.
- `dbus_be_o` output 4: byte enables.
- `dbus_wdata_o` output 32: lane-replicated store data.
- `dbus_gnt_i` input 1: bus accepted the request this cycle.
- `dbus_rvalid_i` input 1: read data valid.
- `dbus_rdata_i` input 32: read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - A handshake occurs when `req_valid_i & req_ready_o & (mem_read_i | mem_write_i)`. On a handshake, latch all request fields.
  - If the access is an error, go to RESP with `err=1`. Otherwise go to REQ.
  - A valid request with neither read nor write asserted is ignored.
- **REQ**
  - `dbus_req_o=1`; bus outputs are driven from the latched fields.
  - On `dbus_gnt_i`: a store goes to RESP; a load goes to WAIT.
- **WAIT**: on `dbus_rvalid_i`, capture and extend the data, then go to RESP.
- **RESP**: `resp_valid_o=1` for exactly one cycle, then go to IDLE.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
- Store data lanes:
  - byte is replicated ×4.
  - half is replicated ×2.
  - word is passed through.
- Load extraction:
  - byte: `rdata >> (8*addr[1:0])`, bits [7:0].
  - half: `rdata >> (16*addr[1])`, bits [15:0].
  - The result is then sign- or zero-extended per `mem_sign`.
- Error conditions:
  - `mem_width=11` is always an error.
  - Misalignment (half with `addr[0]=1`, word with `addr[1:0]≠0`) is handled per Configuration.
  - An error never asserts `dbus_req_o`.
- `dbus_rvalid_i` outside WAIT is ignored.
- If both `mem_read_i` and `mem_write_i` are set, the access is treated as a store.

## Timing
- Reset values:
  - state IDLE
  - `req_ready_o=1`
  - `resp_valid_o=0`, `resp_rdata_o=0`, `resp_rd_o=0`, `resp_err_o=0`
  - `dbus_req_o=0`, `dbus_we_o=0`, `dbus_addr_o=0`, `dbus_be_o=0`, `dbus_wdata_o=0`
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- Load, best case: accept at T0, `dbus_req_o` at T1 with gnt, rvalid at T2, `resp_valid_o` at T3, `req_ready_o` high again at T4.
- Store, best case: accept at T0, req+gnt at T1, `resp_valid_o` at T2, ready at T3.
- Error: accept at T0, `resp_valid_o`+`resp_err_o` at T1, ready at T2.
- Each cycle without gnt in REQ adds one cycle. Each cycle without rvalid in WAIT adds one cycle.
- `rvalid` may arrive in the cycle immediately after gnt, or any cycle later.
- Asynchronous reset in any state:
  - `dbus_req_o` drops immediately and the FSM returns to IDLE.
  - An in-flight rvalid arriving after reset is discarded.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned half/word access completes as an error response, with no bus access.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - A misaligned access proceeds at natural alignment: `addr[0]` is cleared for half, `addr[1:0]` cleared for word. Byte enables and extraction use the cleared address.
  - Only width 11 produces `resp_err_o`.

## Test plan
- LW at `0x1000`, rdata `0xDEADBEEF`, gnt at T1, rvalid at T2, rd=5 -> `resp_valid_o` at T3 with `0xDEADBEEF`, rd=5, err=0; `dbus_be_o=1111`.
- LB / LBU at `0x1003` with rdata `0x80xxxxxx` -> LB returns `0xFFFFFF80` and LBU returns `0x00000080`; `dbus_addr_o=0x1000`, `be=1000`.
- SH at `0x2002`, `wdata_i=0x1234ABCD` -> `dbus_wdata_o=0xABCDABCD`, `be=1100`, `we=1`; gnt delayed 3 cycles holds `dbus_req_o` high; `resp_valid_o` the cycle after gnt with `rdata=0`.
- LW at `0x1001`:
  - With the macro: `resp_err_o=1` at T1 and `dbus_req_o` never asserts.
  - Without the macro: bus address `0x1000`, `err=0`.
  - Width 11 -> err in both builds.
- `rst_ni` pulled low while in WAIT -> `dbus_req_o=0`, `req_ready_o=1` immediately; a later `dbus_rvalid_i` produces no `resp_valid_o`.
- `req_valid_i` held high during a busy load -> `req_ready_o=0` until T4; the second request is accepted exactly once.
